axi4_rd_arb: RTL and testbench
==============================

Name: axi4_rd_arb

Overview:
- Two-requester AXI4 read-channel arbiter (AR/R) in front of the single AXI4 read master port of riscv_top.
- Requester 0 is instruction fetch; requester 1 is data load.
- Grants one requester at a time with round-robin fairness, forwards its AR beat downstream, then steers R beats back until RLAST completes.
- One outstanding transaction total; write channels are not touched.

Parameters:
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width
- ID_W, 4, AR/R ID width; IDs pass through unmodified

Ports:
- clock  in  1  system clock (AXI ACLK)
- reset  in  1  synchronous, active-high reset
- mN_arvalid  in  1  requester N (N=0,1) address valid
- mN_arready  out  1  requester N address ready
- mN_araddr  in  ADDR_W  requester N address
- mN_arid  in  ID_W  requester N ID
- mN_arlen  in  8  requester N burst length-1
- mN_arsize  in  3  requester N beat size
- mN_arburst  in  2  requester N burst type
- mN_rvalid  out  1  requester N read data valid
- mN_rready  in  1  requester N read data ready
- mN_rdata  out  DATA_W  requester N read data
- mN_rresp  out  2  requester N response
- mN_rid  out  ID_W  requester N response ID
- mN_rlast  out  1  requester N last beat
- s_arvalid  out  1  downstream address valid
- s_arready  in  1  downstream address ready
- s_araddr  out  ADDR_W  downstream address
- s_arid, s_arlen, s_arsize, s_arburst  out  ID_W/8/3/2  downstream AR fields
- s_rvalid  in  1  downstream read valid
- s_rready  out  1  downstream read ready
- s_rdata  in  DATA_W  downstream read data
- s_rresp  in  2  downstream response
- s_rid  in  ID_W  downstream response ID
- s_rlast  in  1  downstream last beat

Behaviour:
- Clock and reset: one clock `clock`; `reset` is synchronous and active-high.
- State register: IDLE, ADDR, DATA. Grant register: gnt (0/1). Round-robin pointer: last (0/1).
- Reset: state=IDLE, gnt=0, last=1 (so requester 0 wins the first tie).
  - All outputs are 0 during and after reset until a grant: s_arvalid, mN_arready, mN_rvalid, s_rready.
- IDLE:
  - No outputs asserted.
  - If exactly one mN_arvalid=1: gnt<=N, go to ADDR.
  - If both are 1: gnt<=~last, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - s_arvalid=m[gnt]_arvalid; s_ar* fields are muxed combinationally from m[gnt].
  - m[gnt]_arready=s_arready; the other requester's arready=0.
  - On the s_arvalid&s_arready handshake: go to DATA.
  - Latency: requester arvalid at cycle T gives s_arvalid at T+1 (registered grant). Zero added latency on arready.
- DATA:
  - s_rready=m[gnt]_rready. m[gnt]_rvalid=s_rvalid; m[gnt]_r* fields=s_r*.
  - The other requester sees rvalid=0. Its rdata/rresp/rid/rlast are driven 0.
  - On s_rvalid&s_rready&s_rlast: last<=gnt, go to IDLE.
  - Next grant is evaluated in that IDLE cycle, so there is 1 idle cycle between transactions.
- The non-granted requester's arready is held at 0 for the whole transaction. Its arvalid/AR fields must stay stable per AXI; this is not checked here.
- Requester 0 is never starved: after requester 1 completes, requester 0 wins any tie, and vice versa.
- IDs and arlen are passed through unchanged. The beat count is not checked; termination is by RLAST only.
- Arbitration does not change while in ADDR or DATA, even if the granted arvalid drops (a protocol violation). In that case s_arvalid follows the drop and the block waits.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The downstream slave shares the reset, so no drain is performed.

Optional Feature:
- Macro: AXI4_RD_ARB_FIXED_PRIO_EN.
- Defined: requester 0 (instruction fetch) always wins ties in IDLE; `last` is not used.
- Not defined: round-robin as above.
- Grant latency and the handshake rules are identical in both builds.

Test Plan:
- Reset, then m0_arvalid=1 alone with araddr=0x1000, arlen=0, s_arready=1, s_rvalid/s_rlast=1 with rdata=0xDEADBEEF -> required response:
  - s_arvalid at cycle+1 with s_araddr=0x1000.
  - m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_rlast=1; m1_rvalid=0.
  - Back to IDLE.
- Both arvalid high continuously, arlen=0 each, slave responds immediately -> grants alternate 0,1,0,1 over 4 transactions (with FIXED_PRIO_EN: 0,0,0,0).
- m1 burst with arlen=3, s_rlast only on the 4th beat -> 4 beats forwarded to m1, state stays DATA until beat 4; an m0 request arriving mid-burst sees arready=0 until after completion.
- Downstream backpressure: s_arready=0 for 5 cycles -> s_arvalid held and m[gnt]_arready=0 for 5 cycles; handshake on cycle 6; s_ar* fields stable throughout.
- m0_rready=0 while s_rvalid=1 -> s_rready=0, beat held; beat accepted on the cycle m0_rready rises.
- reset asserted during DATA of an arlen=7 burst after 3 beats -> next cycle state IDLE, all valids/readys 0, last=1; a new m1 request is then granted normally.

Source files
------------

// File: rtl/axi4_rd_arb.sv
// Two-requester AXI4 read arbiter (AR/R), one outstanding transaction, round-robin grant.
// Define AXI4_RD_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module axi4_rd_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic [ID_W-1:0]   m0_rid,
  output logic              m0_rlast,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic [ID_W-1:0]   m1_rid,
  output logic              m1_rlast,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic [ID_W-1:0]   s_rid,
  input  logic              s_rlast
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;

  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m0_rid     = '0;
    m0_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    m1_rid     = '0;
    m1_rlast   = 1'b0;
    s_araddr   = gnt_q ? m1_araddr  : m0_araddr;
    s_arid     = gnt_q ? m1_arid    : m0_arid;
    s_arlen    = gnt_q ? m1_arlen   : m0_arlen;
    s_arsize   = gnt_q ? m1_arsize  : m0_arsize;
    s_arburst  = gnt_q ? m1_arburst : m0_arburst;

    case (state_q)
      ST_IDLE: begin
        if (m0_arvalid && m1_arvalid) begin
`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
          gnt_d = 1'b0;
`else
          gnt_d = ~last_q;
`endif
          state_d = ST_ADDR;
        end else if (m0_arvalid) begin
          gnt_d   = 1'b0;
          state_d = ST_ADDR;
        end else if (m1_arvalid) begin
          gnt_d   = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_arvalid = gnt_q ? m1_arvalid : m0_arvalid;
        if (gnt_q) m1_arready = s_arready;
        else       m0_arready = s_arready;
        if (s_arvalid && s_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_rready = gnt_q ? m1_rready : m0_rready;
        if (gnt_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rid    = s_rid;
          m1_rlast  = s_rlast;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rid    = s_rid;
          m0_rlast  = s_rlast;
        end
        // transaction ends on the accepted RLAST beat only
        if (s_rvalid && s_rready && s_rlast) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_rd_arb.sv
// Directed self-checking bench for axi4_rd_arb.
module tb_axi4_rd_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  axi4_rd_arb dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rid(m0_rid), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rid(m1_rid), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 3'd2; m0_arburst = 2'd1;
    m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 3'd2; m1_arburst = 2'd1;
    m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rid = 0; s_rlast = 0;
  endtask

  // Reset with requests pending; every valid/ready must stay low
  task automatic apply_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1; m0_arvalid = 1; m1_arvalid = 1; s_arready = 1; s_rvalid = 1;
    m0_rready = 1; m1_rready = 1;
    repeat (2) @(negedge clock);
    #1;
    check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst_arready", 64'({m0_arready, m1_arready}), 64'd0);
    check("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
    check("rst_s_rready", 64'(s_rready), 64'd0);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int exp_g;
    reset = 1;
    clear_inputs();

    // Single m0 read
    apply_reset();
    @(negedge clock);
    reset = 0; m0_arvalid = 1; m0_araddr = 32'h1000; m0_arid = 4'd3; s_arready = 1;
    #1;
    check("t1_idle_s_arvalid", 64'(s_arvalid), 64'd0);
    check("t1_idle_m0_arready", 64'(m0_arready), 64'd0);
    @(negedge clock); #1;
    check("t1_addr_s_arvalid", 64'(s_arvalid), 64'd1);
    check("t1_addr_s_araddr", 64'(s_araddr), 64'h1000);
    check("t1_addr_s_arid", 64'(s_arid), 64'd3);
    check("t1_addr_arready", 64'({m0_arready, m1_arready}), 64'b10);
    @(negedge clock);
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'hDEADBEEF; s_rid = 4'd3; m0_rready = 1;
    #1;
    check("t1_data_m0_rvalid", 64'(m0_rvalid), 64'd1);
    check("t1_data_m0_rdata", 64'(m0_rdata), 64'hDEADBEEF);
    check("t1_data_m0_rid", 64'(m0_rid), 64'd3);
    check("t1_data_m0_rlast", 64'(m0_rlast), 64'd1);
    check("t1_data_m1_rvalid", 64'(m1_rvalid), 64'd0);
    check("t1_data_m1_rdata", 64'(m1_rdata), 64'd0);
    check("t1_data_s_rready", 64'(s_rready), 64'd1);
    @(negedge clock); #1;
    check("t1_back_idle_m0_rvalid", 64'(m0_rvalid), 64'd0);
    check("t1_back_idle_s_rready", 64'(s_rready), 64'd0);
    check("t1_back_idle_m0_arready", 64'(m0_arready), 64'd0);

    // Continuous contention
    apply_reset();
    @(negedge clock);
    reset = 0;
    m0_arvalid = 1; m0_araddr = 32'h2000; m1_arvalid = 1; m1_araddr = 32'h3000;
    s_arready = 1; s_rvalid = 1; s_rlast = 1; m0_rready = 1; m1_rready = 1;
    for (int t = 0; t < 4; t++) begin
`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = t % 2;
`endif
      #1;
      check($sformatf("t2_idle%0d_arready", t), 64'({m0_arready, m1_arready}), 64'd0);
      check($sformatf("t2_idle%0d_rvalid", t), 64'({m0_rvalid, m1_rvalid}), 64'd0);
      @(negedge clock); #1;
      check($sformatf("t2_addr%0d_arready", t), 64'({m0_arready, m1_arready}),
            (exp_g == 1) ? 64'b01 : 64'b10);
      check($sformatf("t2_addr%0d_araddr", t), 64'(s_araddr),
            (exp_g == 1) ? 64'h3000 : 64'h2000);
      @(negedge clock); #1;
      check($sformatf("t2_data%0d_rvalid", t), 64'({m0_rvalid, m1_rvalid}),
            (exp_g == 1) ? 64'b01 : 64'b10);
      @(negedge clock);
    end

    // m1 burst of 4 with m0 arriving mid-burst
    apply_reset();
    @(negedge clock);
    reset = 0; m1_arvalid = 1; m1_araddr = 32'h4000; m1_arid = 4'd5; m1_arlen = 8'd3; s_arready = 1;
    #1;
    check("t3_idle_m1_arready", 64'(m1_arready), 64'd0);
    @(negedge clock); #1;
    check("t3_addr_s_arlen", 64'(s_arlen), 64'd3);
    check("t3_addr_s_arid", 64'(s_arid), 64'd5);
    check("t3_addr_m1_arready", 64'(m1_arready), 64'd1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      m1_arvalid = 0; m0_arvalid = 1; m0_araddr = 32'h1100;
      s_rvalid = 1; s_rlast = (b == 3); s_rdata = 32'hB000 + 32'(b); m1_rready = 1;
      #1;
      check($sformatf("t3_beat%0d_m1_rvalid", b), 64'(m1_rvalid), 64'd1);
      check($sformatf("t3_beat%0d_m1_rdata", b), 64'(m1_rdata), 64'hB000 + 64'(b));
      check($sformatf("t3_beat%0d_m1_rlast", b), 64'(m1_rlast), (b == 3) ? 64'd1 : 64'd0);
      check($sformatf("t3_beat%0d_m0_arready", b), 64'(m0_arready), 64'd0);
      check($sformatf("t3_beat%0d_s_arvalid", b), 64'(s_arvalid), 64'd0);
    end
    @(negedge clock);
    s_rvalid = 0; s_rlast = 0;
    #1;
    check("t3_after_idle_m0_arready", 64'(m0_arready), 64'd0);
    @(negedge clock); #1;
    check("t3_after_addr_m0_arready", 64'(m0_arready), 64'd1);
    check("t3_after_addr_s_araddr", 64'(s_araddr), 64'h1100);

    // AR backpressure then R backpressure
    apply_reset();
    @(negedge clock);
    reset = 0; m0_arvalid = 1; m0_araddr = 32'h5000; m0_arlen = 8'd2; s_arready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      check($sformatf("t4_bp%0d_s_arvalid", c), 64'(s_arvalid), 64'd1);
      check($sformatf("t4_bp%0d_m0_arready", c), 64'(m0_arready), 64'd0);
      check($sformatf("t4_bp%0d_s_araddr", c), 64'(s_araddr), 64'h5000);
      check($sformatf("t4_bp%0d_s_arlen", c), 64'(s_arlen), 64'd2);
    end
    @(negedge clock);
    s_arready = 1;
    #1;
    check("t4_hs_s_arvalid", 64'(s_arvalid), 64'd1);
    check("t4_hs_m0_arready", 64'(m0_arready), 64'd1);
    @(negedge clock);
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'hA5A5; m0_rready = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("t5_hold%0d_s_rready", c), 64'(s_rready), 64'd0);
      check($sformatf("t5_hold%0d_m0_rvalid", c), 64'(m0_rvalid), 64'd1);
      @(negedge clock);
    end
    m0_rready = 1;
    #1;
    check("t5_accept_s_rready", 64'(s_rready), 64'd1);
    check("t5_accept_m0_rdata", 64'(m0_rdata), 64'hA5A5);
    @(negedge clock); #1;
    check("t5_done_m0_rvalid", 64'(m0_rvalid), 64'd0);

    // Reset in the middle of an 8-beat burst
    apply_reset();
    @(negedge clock);
    reset = 0; m0_arvalid = 1; m0_araddr = 32'h6000; m0_arlen = 8'd7; s_arready = 1;
    @(negedge clock);
    @(negedge clock);
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 0; m0_rready = 1;
    for (int b = 0; b < 3; b++) begin
      s_rdata = 32'hC000 + 32'(b);
      #1;
      check($sformatf("t6_beat%0d_m0_rvalid", b), 64'(m0_rvalid), 64'd1);
      @(negedge clock);
    end
    reset = 1;
    @(negedge clock);
    reset = 0; m1_arvalid = 1; m1_araddr = 32'h7000;
    #1;
    check("t6_rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
    check("t6_rst_s_rready", 64'(s_rready), 64'd0);
    check("t6_rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("t6_rst_arready", 64'({m0_arready, m1_arready}), 64'd0);
    @(negedge clock); #1;
    check("t6_new_arready", 64'({m0_arready, m1_arready}), 64'b01);
    check("t6_new_s_araddr", 64'(s_araddr), 64'h7000);
    @(negedge clock);
    m1_arvalid = 0; s_rlast = 1; s_rdata = 32'h77; m1_rready = 1;
    #1;
    check("t6_new_m1_rvalid", 64'(m1_rvalid), 64'd1);
    check("t6_new_m1_rdata", 64'(m1_rdata), 64'h77);
    check("t6_new_m0_rvalid", 64'(m0_rvalid), 64'd0);
    @(negedge clock);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
